// File: rtl/rob_pkg.sv
// rob_pkg: shared sizes, FSM/scan enums and exception codes for the ROB commit reader
package rob_pkg;
  localparam int BANKS = 4;
  localparam int ROWS = 128;
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(BANKS);
  localparam int CW = $clog2(BANKS + 1);
  localparam int PRW = 8;
  localparam int EXW = 8;
  typedef enum logic [1:0] {RUN, EXC_WAIT, REDIRECT} state_e;
  typedef enum logic [1:0] {STOP_NONE, STOP_EXC, STOP_MISP} stop_e;
  localparam logic [EXW-1:0] EXC_INSN_MISALIGN = 8'h00;
  localparam logic [EXW-1:0] EXC_ILLEGAL_INSN = 8'h02;
  localparam logic [EXW-1:0] EXC_BREAKPOINT = 8'h03;
  localparam logic [EXW-1:0] EXC_LOAD_FAULT = 8'h05;
  localparam logic [EXW-1:0] EXC_STORE_FAULT = 8'h07;
  localparam logic [EXW-1:0] EXC_ECALL = 8'h0b;
endpackage

// File: rtl/rob_commit_reader_if.sv
// rob_commit_reader_if: head-row read bus, retire outputs and CSR/front-end flush signals
interface rob_commit_reader_if;
  import rob_pkg::*;
  logic [RW-1:0] head_row;
  logic [BW-1:0] head_bank;
  logic [BANKS-1:0] rob_valid;
  logic [BANKS-1:0] rob_rdy;
  logic [BANKS-1:0] rob_has_exc;
  logic [BANKS*EXW-1:0] rob_exc_type;
  logic [BANKS-1:0] rob_mispred;
  logic [BANKS*32-1:0] rob_target;
  logic [BANKS*32-1:0] rob_pc;
  logic [BANKS-1:0] rob_is_store;
  logic [BANKS-1:0] rob_has_rd;
  logic [BANKS*5-1:0] rob_rd;
  logic [BANKS*PRW-1:0] rob_pd;
  logic [BANKS*PRW-1:0] rob_oldpd;
  logic store_stall;
  logic [BANKS-1:0] commit_mask;
  logic [CW-1:0] commit_cnt;
  logic [BANKS*PRW-1:0] free_oldpd;
  logic [BANKS-1:0] arat_wen;
  logic exc_req;
  logic [31:0] exc_pc;
  logic [EXW-1:0] exc_type;
  logic exc_ack;
  logic flush;
  logic [31:0] redirect_pc;
  modport master (
    output head_row, head_bank, commit_mask, commit_cnt, free_oldpd, arat_wen,
           exc_req, exc_pc, exc_type, flush, redirect_pc,
    input  rob_valid, rob_rdy, rob_has_exc, rob_exc_type, rob_mispred, rob_target,
           rob_pc, rob_is_store, rob_has_rd, rob_rd, rob_pd, rob_oldpd, store_stall, exc_ack
  );
  modport slave (
    input  head_row, head_bank, commit_mask, commit_cnt, free_oldpd, arat_wen,
           exc_req, exc_pc, exc_type, flush, redirect_pc,
    output rob_valid, rob_rdy, rob_has_exc, rob_exc_type, rob_mispred, rob_target,
           rob_pc, rob_is_store, rob_has_rd, rob_rd, rob_pd, rob_oldpd, store_stall, exc_ack
  );
endinterface

// File: rtl/rob_commit_scan.sv
// rob_commit_scan: in-order priority scan of the head row from head_bank upward
module rob_commit_scan
  import rob_pkg::*;
(
  input  logic [BW-1:0]    head_bank_i,
  input  logic [BANKS-1:0] valid_i,
  input  logic [BANKS-1:0] rdy_i,
  input  logic [BANKS-1:0] has_exc_i,
  input  logic [BANKS-1:0] mispred_i,
  input  logic [BANKS-1:0] is_store_i,
  input  logic             store_stall_i,
  output logic [BANKS-1:0] mask_o,
  output stop_e            stop_o,
  output logic [BW-1:0]    stop_bank_o
);
  logic go;
  logic ok;
  // walk banks oldest-first; go drops at the first entry that cannot retire or ends the group
  always_comb begin
    mask_o = '0;
    stop_o = STOP_NONE;
    stop_bank_o = '0;
    go = 1'b1;
    ok = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      if (go && BW'(b) >= head_bank_i) begin
        ok = valid_i[b] & rdy_i[b];
        if (ok & has_exc_i[b]) begin
          stop_o = STOP_EXC;
          stop_bank_o = BW'(b);
          go = 1'b0;
        end else if (ok & ~(is_store_i[b] & store_stall_i)) begin
          mask_o[b] = 1'b1;
          stop_o = mispred_i[b] ? STOP_MISP : stop_o;
          stop_bank_o = mispred_i[b] ? BW'(b) : stop_bank_o;
          go = ~mispred_i[b];
        end else begin
          go = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/rob_commit_reader.sv
// rob_commit_reader: in-order ROB retire, head pointer, exception hand-off and mispredict flush
module rob_commit_reader
  import rob_pkg::*;
(
  input  logic clk,
  input  logic rst,
  rob_commit_reader_if.master bus
);
  state_e state_q;
  logic [RW-1:0] head_row_q, head_row_d;
  logic [BW-1:0] head_bank_q, head_bank_d;
  logic exc_req_q;
  logic [31:0] exc_pc_q;
  logic [EXW-1:0] exc_type_q;
  logic flush_q;
  logic [31:0] redirect_pc_q;
  logic [BANKS-1:0] scan_mask, mask;
  stop_e stop;
  logic [BW-1:0] stop_bank;
  logic [CW-1:0] cnt;
  logic [BW:0] bank_sum;
  logic [31:0] sel_pc, sel_target;
  logic [EXW-1:0] sel_type;
  rob_commit_scan u_scan (
    .head_bank_i  (head_bank_q),
    .valid_i      (bus.rob_valid),
    .rdy_i        (bus.rob_rdy),
    .has_exc_i    (bus.rob_has_exc),
    .mispred_i    (bus.rob_mispred),
    .is_store_i   (bus.rob_is_store),
    .store_stall_i(bus.store_stall),
    .mask_o       (scan_mask),
    .stop_o       (stop),
    .stop_bank_o  (stop_bank)
  );
  // retire outputs only in RUN and never while reset is held; select the stopping entry's payload
  always_comb begin
    mask = (rst && state_q == RUN) ? scan_mask : '0;
    cnt = '0;
    sel_pc = '0;
    sel_target = '0;
    sel_type = '0;
    bus.free_oldpd = '0;
    for (int b = 0; b < BANKS; b++) begin
      cnt = cnt + CW'(mask[b]);
      bus.free_oldpd[b*PRW +: PRW] = (mask[b] & bus.rob_has_rd[b]) ? bus.rob_oldpd[b*PRW +: PRW] : '0;
      sel_pc = (BW'(b) == stop_bank) ? bus.rob_pc[b*32 +: 32] : sel_pc;
      sel_target = (BW'(b) == stop_bank) ? bus.rob_target[b*32 +: 32] : sel_target;
      sel_type = (BW'(b) == stop_bank) ? bus.rob_exc_type[b*EXW +: EXW] : sel_type;
    end
    bus.commit_mask = mask;
    bus.commit_cnt = cnt;
    bus.arat_wen = mask & bus.rob_has_rd;
    bank_sum = {1'b0, head_bank_q} + (BW+1)'(cnt);
    head_bank_d = (bank_sum == (BW+1)'(BANKS)) ? '0 : bank_sum[BW-1:0];
    head_row_d = (bank_sum != (BW+1)'(BANKS)) ? head_row_q :
                 (head_row_q == RW'(ROWS-1)) ? '0 : head_row_q + 1'b1;
  end
  // FSM: retire in RUN, hold the exception until acked, emit a one-cycle flush that rewinds the head
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      head_row_q <= '0;
      head_bank_q <= '0;
      exc_req_q <= 1'b0;
      exc_pc_q <= '0;
      exc_type_q <= '0;
      flush_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (stop == STOP_MISP) begin
            state_q <= REDIRECT;
            flush_q <= 1'b1;
            redirect_pc_q <= sel_target;
            head_row_q <= '0;
            head_bank_q <= '0;
          end else begin
            head_row_q <= head_row_d;
            head_bank_q <= head_bank_d;
            if (stop == STOP_EXC) begin
              state_q <= EXC_WAIT;
              exc_req_q <= 1'b1;
              exc_pc_q <= sel_pc;
              exc_type_q <= sel_type;
            end
          end
        end
        EXC_WAIT: begin
          if (bus.exc_ack) begin
            state_q <= REDIRECT;
            exc_req_q <= 1'b0;
            flush_q <= 1'b1;
            redirect_pc_q <= '0;
            head_row_q <= '0;
            head_bank_q <= '0;
          end
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end
  assign bus.head_row = head_row_q;
  assign bus.head_bank = head_bank_q;
  assign bus.exc_req = exc_req_q;
  assign bus.exc_pc = exc_pc_q;
  assign bus.exc_type = exc_type_q;
  assign bus.flush = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_rob_commit_reader.sv
// tb_rob_commit_reader: directed + random scoreboard bench against a linear-pointer retire model
module tb_rob_commit_reader;
  import rob_pkg::*;
  typedef struct {
    logic [3:0] mask;
    logic [2:0] cnt;
    logic [31:0] free;
    logic [3:0] arat;
    logic [6:0] row;
    logic [1:0] bank;
    logic exc_req;
    logic [31:0] epc;
    logic [7:0] etype;
    logic flush;
    logic [31:0] redir;
    bit full;
  } exp_t;
  logic clk, rst;
  rob_commit_reader_if bus();
  rob_commit_reader dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int pos = 0, mode = 0;
  logic [31:0] m_epc = 0, m_redir = 0;
  logic [7:0] m_etype = 0;
  bit after_rst = 1;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic payload();
    bus.rob_pc = {$urandom, $urandom, $urandom, $urandom};
    bus.rob_target = {$urandom, $urandom, $urandom, $urandom};
    bus.rob_exc_type = $urandom;
    bus.rob_has_rd = 4'($urandom);
    bus.rob_rd = 20'($urandom);
    bus.rob_pd = $urandom;
    bus.rob_oldpd = $urandom;
  endtask
  // drive one cycle, push its expected outputs, then advance the model past the clock edge
  task automatic cyc(input logic [3:0] v, r, x, m, s, input logic st, ak, rs);
    exp_t e;
    int hb, n, sb;
    bit hm, he;
    logic [3:0] mk;
    bus.rob_valid = v; bus.rob_rdy = r; bus.rob_has_exc = x; bus.rob_mispred = m;
    bus.rob_is_store = s; bus.store_stall = st; bus.exc_ack = ak; rst = rs;
    hb = pos % 4; n = 0; sb = 0; hm = 0; he = 0; mk = 0;
    if (mode == 0 && rs)
      for (int b = hb; b < 4; b++) begin
        if (!(v[b] && r[b])) break;
        if (x[b]) begin he = 1; sb = b; break; end
        if (s[b] && st) break;
        mk[b] = 1; n++;
        if (m[b]) begin hm = 1; sb = b; break; end
      end
    e.mask = mk; e.cnt = 3'(n); e.arat = mk & bus.rob_has_rd; e.free = 0;
    for (int b = 0; b < 4; b++) if (e.arat[b]) e.free[b*8 +: 8] = bus.rob_oldpd[b*8 +: 8];
    e.row = 7'(pos / 4); e.bank = 2'(pos % 4);
    e.exc_req = (mode == 1); e.epc = m_epc; e.etype = m_etype;
    e.flush = (mode == 2); e.redir = m_redir; e.full = after_rst;
    q.push_back(e);
    after_rst = 0;
    if (!rs) begin
      pos = 0; mode = 0; m_epc = 0; m_etype = 0; m_redir = 0; after_rst = 1;
    end else if (mode == 0) begin
      if (hm) begin
        mode = 2; m_redir = bus.rob_target[sb*32 +: 32]; pos = 0;
      end else begin
        pos = (pos + n) % (4 * 128);
        if (he) begin
          mode = 1; m_epc = bus.rob_pc[sb*32 +: 32]; m_etype = bus.rob_exc_type[sb*8 +: 8];
        end
      end
    end else if (mode == 1) begin
      if (ak) begin mode = 2; m_redir = 0; pos = 0; end
    end else mode = 0;
    @(posedge clk); #1;
  endtask
  task automatic go(input logic [3:0] vr, x, m, s, input logic st, ak);
    payload();
    cyc(vr, vr, x, m, s, st, ak, 1'b1);
  endtask
  task automatic advance_to(input int row, input int bank);
    for (int i = 0; i < 600 && pos / 4 != row; i++) go(4'hf, 0, 0, 0, 0, 0);
    if (bank > 0) go(4'((1 << bank) - 1), 0, 0, 0, 0, 0);
  endtask
  // monitor: pop one expectation per cycle and compare away from the clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("commit_mask", 64'(bus.commit_mask), 64'(e.mask));
        chk("commit_cnt", 64'(bus.commit_cnt), 64'(e.cnt));
        chk("free_oldpd", 64'(bus.free_oldpd), 64'(e.free));
        chk("arat_wen", 64'(bus.arat_wen), 64'(e.arat));
        chk("head_row", 64'(bus.head_row), 64'(e.row));
        chk("head_bank", 64'(bus.head_bank), 64'(e.bank));
        chk("exc_req", 64'(bus.exc_req), 64'(e.exc_req));
        chk("flush", 64'(bus.flush), 64'(e.flush));
        if (e.exc_req || e.full) begin
          chk("exc_pc", 64'(bus.exc_pc), 64'(e.epc));
          chk("exc_type", 64'(bus.exc_type), 64'(e.etype));
        end
        if (e.flush || e.full) chk("redirect_pc", 64'(bus.redirect_pc), 64'(e.redir));
      end
    end
  end
  initial begin
    rst = 0;
    payload();
    bus.rob_valid = 0; bus.rob_rdy = 0; bus.rob_has_exc = 0; bus.rob_mispred = 0;
    bus.rob_is_store = 0; bus.store_stall = 0; bus.exc_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    go(4'hf, 0, 0, 0, 0, 0);
    advance_to(5, 1);
    go(4'b0110, 0, 0, 0, 0, 0);
    go(4'b1000, 0, 0, 0, 0, 0);
    advance_to(127, 2);
    go(4'b1100, 0, 0, 0, 0, 0);
    go(4'h0, 0, 0, 0, 0, 0);
    payload();
    bus.rob_target[63:32] = 32'h8000_1000;
    cyc(4'b0011, 4'b0011, 0, 4'b0010, 0, 0, 0, 1);
    go(4'hf, 0, 0, 0, 0, 0);
    payload();
    bus.rob_pc[95:64] = 32'h8000_0040;
    bus.rob_exc_type[23:16] = EXC_LOAD_FAULT;
    cyc(4'b0111, 4'b0111, 4'b0100, 0, 0, 0, 0, 1);
    repeat (3) go(4'hf, 0, 0, 0, 0, 0);
    go(4'hf, 0, 0, 0, 0, 1);
    go(4'hf, 0, 0, 0, 0, 0);
    go(4'hf, 0, 0, 4'b0001, 1, 0);
    go(4'h0, 0, 0, 0, 0, 1);
    go(4'b0001, 4'b0001, 0, 0, 0, 0);
    go(4'hf, 0, 0, 0, 0, 0);
    payload();
    cyc(4'hf, 4'hf, 0, 0, 0, 0, 0, 0);
    go(4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      payload();
      cyc(4'($urandom | $urandom), 4'($urandom | $urandom), 4'($urandom & $urandom & $urandom),
          4'($urandom & $urandom & $urandom), 4'($urandom & $urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 49) != 0);
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
